// File: rtl/jtag_debug_cmd_sync_pkg.sv
// Shared definitions for the system-clock side of the JTAG debug command path.
//   state_e     : command FSM states
//   Def*        : default parameter values for the top level
//   ir_onehot() : one-hot decode of an instruction value (result is truncated by the caller)
package jtag_dbg_pkg;

  localparam int unsigned DefDrWidth    = 38;
  localparam int unsigned DefIrWidth    = 2;
  localparam int unsigned DefSyncStages = 2;

  // Widest instruction the decode helper supports.
  localparam int unsigned MaxIrWidth    = 8;
  localparam int unsigned MaxNumCmd     = 1 << MaxIrWidth;

  typedef enum logic {
    StIdle,
    StHold
  } state_e;

  function automatic logic [MaxNumCmd-1:0] ir_onehot(input logic [MaxIrWidth-1:0] ir);
    ir_onehot = MaxNumCmd'(1) << ir;
  endfunction

endpackage

// File: rtl/jtag_debug_cmd_sync_if.sv
// Command handshake between the JTAG debug synchroniser and the debug/OCI consumer.
//   jdo / cmd_ir   : captured data register and instruction of the pending command
//   cmd_valid      : command pending; cmd_ready accepts it
//   take_action    : one-hot strobe at acceptance, bit index = cmd_ir
//   ir_update      : one pulse per synchronised Update-IR
//   overrun        : sticky, cleared by overrun_clr
// master = synchroniser side, slave = consumer side.
interface jtag_debug_cmd_sync_if #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2
) ();

  localparam int unsigned NUM_CMD = 1 << IR_WIDTH;

  logic [DR_WIDTH-1:0] jdo;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [NUM_CMD-1:0]  take_action;
  logic                ir_update;
  logic                overrun;
  logic                overrun_clr;

  modport master (
    output jdo,
    output cmd_ir,
    output cmd_valid,
    input  cmd_ready,
    output take_action,
    output ir_update,
    output overrun,
    input  overrun_clr
  );

  modport slave (
    input  jdo,
    input  cmd_ir,
    input  cmd_valid,
    output cmd_ready,
    input  take_action,
    input  ir_update,
    input  overrun,
    output overrun_clr
  );

endinterface

// File: rtl/jtag_debug_cmd_sync_toggle_sync.sv
// Toggle synchroniser with edge detect.
//   clk, reset_n : system clock, async active-low reset
//   toggle_in    : TCK-domain toggle flag (asynchronous)
//   arm          : event qualifier; prev keeps tracking even while disarmed
//   event_out    : one-cycle flag when the synchronised toggle changes
// SYNC_STAGES is expected in 2..4.
module jtag_dbg_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic toggle_in,
  input  logic arm,
  output logic event_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign event_out = arm & (sync_q[SYNC_STAGES-1] ^ prev_q);

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// System-clock side of the JTAG debug path.
//   clk, reset_n           : system clock, async active-low reset
//   udr_toggle, uir_toggle : TCK-domain Update-DR / Update-IR toggle flags
//   sr, ir_in              : quasi-static TCK-domain data register and instruction
//   cmd_if (master)        : command handshake, action strobe, ir_update, overrun
// Each Update-DR becomes one command held under valid/ready; acceptance fires a one-hot
// strobe selected by the captured instruction.
module jtag_debug_cmd_sync
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned DR_WIDTH    = DefDrWidth,
  parameter int unsigned IR_WIDTH    = DefIrWidth,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                udr_toggle,
  input  logic                uir_toggle,
  input  logic [DR_WIDTH-1:0] sr,
  input  logic [IR_WIDTH-1:0] ir_in,
  jtag_debug_cmd_sync_if.master cmd_if
);

  localparam int unsigned NUM_CMD     = 1 << IR_WIDTH;
  localparam int unsigned WarmCycles  = SYNC_STAGES + 1;

  // Warm-up: ignore events until the sync chains and prev flops hold the real toggle level,
  // so a toggle that resets to 1 on the TCK side is not mistaken for an update.
  logic [2:0] warm_q;
  logic       arm;

  assign arm = (warm_q == 3'(WarmCycles));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q <= '0;
    end else if (!arm) begin
      warm_q <= warm_q + 3'd1;
    end
  end

  logic dr_evt;
  logic ir_evt;

  jtag_dbg_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dr_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .toggle_in(udr_toggle),
    .arm      (arm),
    .event_out(dr_evt)
  );

  jtag_dbg_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ir_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .toggle_in(uir_toggle),
    .arm      (arm),
    .event_out(ir_evt)
  );

  state_e              state_q;
  logic [DR_WIDTH-1:0] jdo_q;
  logic [IR_WIDTH-1:0] cmd_ir_q;
  logic                cmd_valid_q;
  logic [NUM_CMD-1:0]  take_action_q;
  logic                ir_update_q;
  logic                overrun_q;
  logic [NUM_CMD-1:0]  action_dec;

  assign action_dec = NUM_CMD'(ir_onehot(MaxIrWidth'(cmd_ir_q)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      jdo_q         <= '0;
      cmd_ir_q      <= '0;
      cmd_valid_q   <= 1'b0;
      take_action_q <= '0;
      ir_update_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      take_action_q <= '0;
      ir_update_q   <= ir_evt;
      // Clear first so a same-cycle overrun below takes priority.
      if (cmd_if.overrun_clr) begin
        overrun_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (dr_evt) begin
            jdo_q       <= sr;
            cmd_ir_q    <= ir_in;
            cmd_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (cmd_if.cmd_ready) begin
            take_action_q <= action_dec;
            if (dr_evt) begin
              // Old command retires, new one reloads without dropping valid.
              jdo_q    <= sr;
              cmd_ir_q <= ir_in;
            end else begin
              cmd_valid_q <= 1'b0;
              state_q     <= StIdle;
            end
          end else if (dr_evt) begin
            // Pending command wins; the new update is lost.
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_if.jdo         = jdo_q;
  assign cmd_if.cmd_ir      = cmd_ir_q;
  assign cmd_if.cmd_valid   = cmd_valid_q;
  assign cmd_if.take_action = take_action_q;
  assign cmd_if.ir_update   = ir_update_q;
  assign cmd_if.overrun     = overrun_q;

endmodule

// File: doc/jtag_debug_cmd_sync.md
# jtag_debug_cmd_sync

Parametrised system-clock side of the JTAG debug path. Brings Update-DR and Update-IR events from the TCK domain into `clk` through toggle synchronisers. Captures the shifted data register and instruction, and presents each update as a single command with a valid/ready handshake and a one-hot action strobe. It sits between the virtual-JTAG TCK logic and the CPU's debug/OCI logic, and supersedes the fixed 2-bit-IR, 38-bit-DR, fire-and-forget strobe scheme.

## Interface
- `DR_WIDTH`, 38, width of the shifted data register and of `jdo`
- `IR_WIDTH`, 2, instruction width; `NUM_CMD` = 2**IR_WIDTH action channels
- `SYNC_STAGES`, 2, synchroniser flops per toggle input (legal range 2..4)

Ports:
- `clk`  in  1  system clock; the only clock
- `reset_n`  in  1  reset, asynchronous assert, active-low
- `udr_toggle`  in  1  TCK-domain flag; the source inverts it once per Update-DR; asynchronous to `clk`
- `uir_toggle`  in  1  TCK-domain flag; the source inverts it once per Update-IR
- `sr`  in  DR_WIDTH  TCK-domain shift register; quasi-static, stable from toggle until the next Capture-DR
- `ir_in`  in  IR_WIDTH  current instruction; quasi-static
- `jdo`  out  DR_WIDTH  captured data of the current command
- `cmd_ir`  out  IR_WIDTH  captured instruction of the current command
- `cmd_valid`  out  1  command pending
- `cmd_ready`  in  1  consumer accepts the command
- `take_action`  out  NUM_CMD  one-hot, one-cycle pulse at acceptance; bit index = `cmd_ir`
- `ir_update`  out  1  one-cycle pulse per synchronised Update-IR
- `overrun`  out  1  sticky flag: an Update-DR arrived while a command was pending
- `overrun_clr`  in  1  synchronous clear of `overrun`

## Operation
- Each toggle input passes through `SYNC_STAGES` flops, then a `prev` flop. An event is flagged on the cycle where the last sync stage differs from `prev`.
- Warm-up counter after reset release: all events are discarded for `SYNC_STAGES`+1 cycles, and `prev` tracks the last sync stage throughout. This prevents a false event when the TCK-side toggle resets to a different value.
- FSM states:
  - IDLE: on a DR event, latch `sr` into `jdo` and `ir_in` into `cmd_ir`, then go to HOLD.
  - HOLD: `cmd_valid`=1.
    - `cmd_ready`=1 with no DR event: pulse `take_action[cmd_ir]`, go to IDLE.
    - DR event with no handshake: new data is dropped, `jdo` and `cmd_ir` are kept, `overrun` is set, state stays HOLD.
    - Handshake and DR event in the same cycle: the old command is completed and strobed, the new one is latched, state stays HOLD, `overrun` is not set.
- An IR event pulses `ir_update` in any state and never affects the FSM or `jdo`.
- If `overrun_clr` and a new overrun occur in the same cycle, set wins.
- `cmd_valid` is not withdrawn until accepted. `jdo` and `cmd_ir` are stable while `cmd_valid`=1.

## Timing
- Reset values: `jdo`=0, `cmd_ir`=0, `cmd_valid`=0, `take_action`=0, `ir_update`=0, `overrun`=0. Sync, `prev` and warm-up registers are 0, FSM is IDLE.
- Latency: a toggle edge seen at a `clk` edge gives `cmd_valid` high `SYNC_STAGES`+1 cycles later, registered. `ir_update` has the same latency.
- `take_action` is registered and appears 1 cycle after the accepting `clk` edge, coincident with `cmd_valid` falling (or reloading).
- Minimum spacing for loss-free DR events is `SYNC_STAGES`+1 `clk` cycles between toggles.
- Asserting `reset_n` mid-command clears everything immediately. A toggle flip during reset does not create a command after release.

## Structure
- Package `jtag_dbg_pkg`:
  - FSM state enum (IDLE, HOLD)
  - default-width localparams
  - a function that returns the one-hot decode of an IR value
- Sub-module `jtag_dbg_toggle_sync`: parameter `SYNC_STAGES`; ports `clk`, `reset_n`, `toggle_in`, `arm`, `event_out`. It contains the sync chain, the `prev` flop and the edge detect, and is instantiated twice (DR and IR).
- The top level holds the warm-up counter, FSM, capture registers and overrun flag.

## Test plan
- Defaults; `sr`=38'h2A_1234_5678, `ir_in`=2, flip `udr_toggle`, hold `cmd_ready`=1 -> `cmd_valid` rises 3 cycles later, `take_action`=4'b0100 pulses once, `jdo`=38'h2A_1234_5678.
- `cmd_ready`=0; two DR toggles 10 cycles apart -> first command held with `jdo` unchanged, `overrun`=1; `overrun_clr` -> 0.
- Hold-then-accept with a new DR event landing on the accept cycle -> one strobe for the old `cmd_ir`, new `jdo` latched, `cmd_valid` stays 1, `overrun`=0.
- `udr_toggle` held at 1 through reset release -> no `cmd_valid` within 20 cycles. A later flip to 0 -> exactly one command.
- `uir_toggle` flips while in HOLD -> a single `ir_update` pulse, with FSM, `jdo` and `cmd_valid` unaffected.
- `IR_WIDTH`=3, `DR_WIDTH`=64, `SYNC_STAGES`=3, `ir_in`=7 -> `take_action`=8'h80, latency 4 cycles; `reset_n` low mid-HOLD clears all outputs to 0 in the same cycle.
